// File: rtl/pid_compensator_if.sv
// pid_compensator_if
//   Sample-in / duty-out bundle between the ADC front end, the PID compensator
//   and the DPWM.
//   master : drives vref, adc_data, adc_valid; observes duty_cmd, duty_valid, busy
//   slave  : the compensator; observes the sample, drives the duty command
interface pid_compensator_if #(
  parameter int ADC_W = 8
);
  logic [ADC_W-1:0] vref;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic [8:0]       duty_cmd;
  logic             duty_valid;
  logic             busy;

  modport master (
    output vref, adc_data, adc_valid,
    input  duty_cmd, duty_valid, busy
  );

  modport slave (
    input  vref, adc_data, adc_valid,
    output duty_cmd, duty_valid, busy
  );
endinterface

// File: rtl/pid_compensator.sv
// pid_compensator
//   Velocity-form PID for the buck-converter loop:
//     u[n] = clamp(u[n-1] + KA*e[n] + KB*e[n-1] + KC*e[n-2]),  e = vref - adc_data
//   u is Q(FRAC) in a 24-bit register; one shared signed multiplier is stepped
//   through the three taps. Output is u >> FRAC as a 9-bit duty command.
// Ports:
//   clk  - system clock (same domain as the DPWM)
//   rst  - synchronous active-low reset
//   bus  - pid_compensator_if.slave: vref/adc_data/adc_valid in,
//          duty_cmd/duty_valid/busy out
module pid_compensator #(
  parameter int ADC_W     = 8,
  parameter int COEF_W    = 12,
  parameter int FRAC      = 6,
  parameter int KA        = 64,
  parameter int KB        = 0,
  parameter int KC        = 0,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 480,
  parameter int DUTY_INIT = 256
) (
  input  logic              clk,
  input  logic              rst,
  pid_compensator_if.slave  bus
);

  localparam int E_W   = ADC_W + 1;
  localparam int P_W   = E_W + COEF_W;
  localparam int ACC_W = 24;
  localparam int D_W   = 9;

  localparam logic signed [COEF_W-1:0] KA_C = COEF_W'(KA);
  localparam logic signed [COEF_W-1:0] KB_C = COEF_W'(KB);
  localparam logic signed [COEF_W-1:0] KC_C = COEF_W'(KC);

  localparam logic signed [ACC_W-1:0] U_MIN  = ACC_W'(DUTY_MIN  * (2 ** FRAC));
  localparam logic signed [ACC_W-1:0] U_MAX  = ACC_W'(DUTY_MAX  * (2 ** FRAC));
  localparam logic signed [ACC_W-1:0] U_INIT = ACC_W'(DUTY_INIT * (2 ** FRAC));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_SAT,
    S_OUT
  } state_e;

  state_e                   state_q,     state_d;
  logic [ADC_W-1:0]         vref_q,      vref_d;
  logic [ADC_W-1:0]         adc_q,       adc_d;
  logic signed [E_W-1:0]    e0_q,        e0_d;
  logic signed [E_W-1:0]    e1_q,        e1_d;
  logic signed [E_W-1:0]    e2_q,        e2_d;
  logic signed [ACC_W-1:0]  acc_q,       acc_d;
  logic signed [ACC_W-1:0]  u_q,         u_d;
  logic [D_W-1:0]           duty_cmd_q,  duty_cmd_d;
  logic                     duty_valid_q, duty_valid_d;

  // Shared multiplier: operands are selected by the MAC state.
  logic signed [E_W-1:0]    mul_a;
  logic signed [COEF_W-1:0] mul_b;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sat;

  assign prod     = P_W'(mul_a) * P_W'(mul_b);
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_MAC0:  begin mul_a = e0_q; mul_b = KA_C; end
      S_MAC1:  begin mul_a = e1_q; mul_b = KB_C; end
      S_MAC2:  begin mul_a = e2_q; mul_b = KC_C; end
      default: begin mul_a = '0;   mul_b = '0;   end
    endcase
  end

  // Clamping the stored state (not just the output) is what prevents windup.
  always_comb begin
    acc_sat = acc_q;
    if (acc_q < U_MIN)      acc_sat = U_MIN;
    else if (acc_q > U_MAX) acc_sat = U_MAX;
  end

  always_comb begin
    state_d      = state_q;
    vref_d       = vref_q;
    adc_d        = adc_q;
    e0_d         = e0_q;
    e1_d         = e1_q;
    e2_d         = e2_q;
    acc_d        = acc_q;
    u_d          = u_q;
    duty_cmd_d   = duty_cmd_q;
    duty_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.adc_valid) begin
          vref_d  = bus.vref;
          adc_d   = bus.adc_data;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e0_d    = $signed({1'b0, vref_q}) - $signed({1'b0, adc_q});
        acc_d   = u_q;
        state_d = S_MAC0;
      end
      S_MAC0: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_MAC1;
      end
      S_MAC1: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_SAT;
      end
      S_SAT: begin
        u_d     = acc_sat;
        e2_d    = e1_q;
        e1_d    = e0_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        duty_cmd_d   = u_q[FRAC +: D_W];
        duty_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vref_q       <= '0;
      adc_q        <= '0;
      e0_q         <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      acc_q        <= '0;
      u_q          <= U_INIT;
      duty_cmd_q   <= D_W'(DUTY_INIT);
      duty_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vref_q       <= vref_d;
      adc_q        <= adc_d;
      e0_q         <= e0_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      acc_q        <= acc_d;
      u_q          <= u_d;
      duty_cmd_q   <= duty_cmd_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign bus.duty_cmd   = duty_cmd_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_compensator.sv
// tb_pid_compensator
//   Two compensators (default coefficients, and KA=96/KB=-64/KC=16) driven with
//   identical samples and compared against an arithmetic reference model.
module tb_pid_compensator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pid_compensator_if #(.ADC_W(8)) if0 ();
  pid_compensator_if #(.ADC_W(8)) if1 ();

  pid_compensator u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pid_compensator #(
    .KA (96),
    .KB (-64),
    .KC (16)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one slot per DUT; u in Q6.
  int ka [2] = '{64, 96};
  int kb [2] = '{0, -64};
  int kc [2] = '{0, 16};
  int u_m  [2];
  int e1_m [2];
  int e2_m [2];
  int duty_m [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      u_m[i]    = 256 * 64;
      e1_m[i]   = 0;
      e2_m[i]   = 0;
      duty_m[i] = 256;
    end
  endfunction

  function automatic void model_step(input int e);
    int u;
    for (int i = 0; i < 2; i++) begin
      u = u_m[i] + ka[i] * e + kb[i] * e1_m[i] + kc[i] * e2_m[i];
      if (u < 16 * 64)  u = 16 * 64;
      if (u > 480 * 64) u = 480 * 64;
      u_m[i]    = u;
      e2_m[i]   = e1_m[i];
      e1_m[i]   = e;
      duty_m[i] = u / 64;
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] a);
    if0.adc_valid = v; if0.vref = r; if0.adc_data = a;
    if1.adc_valid = v; if1.vref = r; if1.adc_data = a;
  endtask

  task automatic check_outputs(input string tag, input logic busy_exp, input logic valid_exp);
    check_eq({tag, ".busy0"},  int'(if0.busy),       int'(busy_exp));
    check_eq({tag, ".valid0"}, int'(if0.duty_valid), int'(valid_exp));
    check_eq({tag, ".duty0"},  int'(if0.duty_cmd),   duty_m[0]);
    check_eq({tag, ".busy1"},  int'(if1.busy),       int'(busy_exp));
    check_eq({tag, ".valid1"}, int'(if1.duty_valid), int'(valid_exp));
    check_eq({tag, ".duty1"},  int'(if1.duty_cmd),   duty_m[1]);
  endtask

  // One accepted sample; drop_at (1..6) adds a second strobe sampled at edge
  // t+drop_at, which must be ignored. Ends #1 after edge t+6.
  task automatic run_sample(input logic [7:0] r, input logic [7:0] a, input int drop_at);
    @(negedge clk);
    drive(1'b1, r, a);
    @(posedge clk); #1;
    drive(1'b0, 8'($urandom), 8'($urandom));
    for (int k = 0; k < 6; k++) begin
      check_outputs("busy_phase", 1'b1, 1'b0);
      if (drop_at == k + 1) drive(1'b1, 8'($urandom), 8'($urandom));
      else                  drive(1'b0, 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end
    drive(1'b0, 8'($urandom), 8'($urandom));
    model_step(int'(r) - int'(a));
    check_outputs("result", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(k[0] ? 1'b0 : 1'b1, 8'd200, 8'd10);
      @(posedge clk); #1;
      check_outputs("in_reset", 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_outputs("post_reset", 1'b0, 1'b0);
    end
  endtask

  // Reset lands while the DUTs are in MAC1; nothing of the sample may survive.
  task automatic abort_sample(input logic [7:0] r, input logic [7:0] a);
    @(negedge clk);
    drive(1'b1, r, a);
    @(posedge clk); #1;
    drive(1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_outputs("abort", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 8'd0, 8'd0);
    model_reset();
    do_reset();

    // Single step, then multi-tap sequence e = +8, +8, 0, with a dropped
    // strobe at t+3 on the first sample and one at the OUT edge on the second.
    run_sample(8'd128, 8'd120, 3);
    check_eq("step1.dut0", int'(if0.duty_cmd), 264);
    check_eq("step1.dut1", int'(if1.duty_cmd), 268);
    run_sample(8'd128, 8'd120, 6);
    check_eq("step2.dut0", int'(if0.duty_cmd), 272);
    check_eq("step2.dut1", int'(if1.duty_cmd), 272);
    run_sample(8'd128, 8'd128, 0);
    check_eq("step3.dut0", int'(if0.duty_cmd), 272);
    check_eq("step3.dut1", int'(if1.duty_cmd), 266);

    // Saturation and anti-windup.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_sample(8'd255, 8'd0, 0);
      check_eq("sat.dut0", int'(if0.duty_cmd), 480);
      check_eq("sat.dut1", int'(if1.duty_cmd), 480);
    end
    run_sample(8'd0, 8'd8, 0);
    check_eq("unwind.dut0", int'(if0.duty_cmd), 472);
    check_eq("unwind.dut1", int'(if1.duty_cmd), 276);

    // Reset mid-operation, then the clean-reset single step result again.
    run_sample(8'd90, 8'd30, 0);
    abort_sample(8'd10, 8'd250);
    run_sample(8'd128, 8'd120, 0);
    check_eq("after_abort.dut0", int'(if0.duty_cmd), 264);
    check_eq("after_abort.dut1", int'(if1.duty_cmd), 268);

    // Randomized samples with random dropped strobes and occasional aborts.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0)
        abort_sample(8'($urandom), 8'($urandom));
      else
        run_sample(8'($urandom), 8'($urandom), int'($urandom_range(0, 6)));
    end
    // Small-error random walk around the setpoint.
    for (int n = 0; n < 40; n++) begin
      run_sample(8'd128, 8'(128 + $urandom_range(0, 16) - 8), int'($urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
